// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: decodes UART command bytes into register-file
// writes/reads and ALU operations, and returns results over the UART TX path.
module cmd_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clck,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_p_data,
  input  logic                    rx_d_vld,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_data_vld,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_vld,
  input  logic                    tx_busy,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic [3:0]              alu_fun,
  output logic                    alu_en,
  output logic                    clk_gate_en,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_d_vld
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUN, ALU_WAIT, TX_RD, TX_LSB, TX_MSB
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;
  logic [2*DATA_WIDTH-1:0] result_reg, result_next;
  logic [ADDR_WIDTH-1:0]   rf_addr_reg, rf_addr_next;
  logic                    rf_wr_en_reg, rf_wr_en_next;
  logic                    rf_rd_en_reg, rf_rd_en_next;
  logic [DATA_WIDTH-1:0]   rf_wr_data_reg, rf_wr_data_next;
  logic [3:0]              alu_fun_reg, alu_fun_next;
  logic                    alu_en_reg, alu_en_next;
  logic                    clk_gate_reg, clk_gate_next;
  logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
  logic                    tx_vld_reg, tx_vld_next;

  // Byte to send and successor state for whichever TX state is active.
  logic [DATA_WIDTH-1:0] tx_byte;
  state_t                tx_after;

  always_comb begin
    tx_byte  = rd_data_reg;
    tx_after = IDLE;
    case (state_reg)
      TX_LSB: begin
        tx_byte  = result_reg[DATA_WIDTH-1:0];
        tx_after = TX_MSB;
      end
      TX_MSB: tx_byte = result_reg[2*DATA_WIDTH-1:DATA_WIDTH];
      default: ;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    rd_data_next    = rd_data_reg;
    result_next     = result_reg;
    rf_addr_next    = rf_addr_reg;
    rf_wr_en_next   = 1'b0;
    rf_rd_en_next   = 1'b0;
    rf_wr_data_next = rf_wr_data_reg;
    alu_fun_next    = alu_fun_reg;
    alu_en_next     = 1'b0;
    clk_gate_next   = clk_gate_reg;
    tx_data_next    = tx_data_reg;
    tx_vld_next     = tx_vld_reg;
    case (state_reg)
      IDLE: if (rx_d_vld) begin
        if (rx_p_data == CMD_WR)       state_next = WR_ADDR;
        else if (rx_p_data == CMD_RD)  state_next = RD_ADDR;
        else if (rx_p_data == CMD_OPS) state_next = OP_A;
        else if (rx_p_data == CMD_FUN) state_next = ALU_FUN;
      end
      WR_ADDR: if (rx_d_vld) begin
        addr_next  = rx_p_data[ADDR_WIDTH-1:0];
        state_next = WR_DATA;
      end
      WR_DATA: if (rx_d_vld) begin
        rf_wr_en_next   = 1'b1;
        rf_addr_next    = addr_reg;
        rf_wr_data_next = rx_p_data;
        state_next      = IDLE;
      end
      RD_ADDR: if (rx_d_vld) begin
        rf_rd_en_next = 1'b1;
        addr_next     = rx_p_data[ADDR_WIDTH-1:0];
        rf_addr_next  = rx_p_data[ADDR_WIDTH-1:0];
        state_next    = RD_WAIT;
      end
      RD_WAIT: if (rf_rd_data_vld) begin
        rd_data_next = rf_rd_data;
        state_next   = TX_RD;
      end
      OP_A, OP_B: if (rx_d_vld) begin
        rf_wr_en_next   = 1'b1;
        rf_addr_next    = (state_reg == OP_A) ? '0 : ADDR_WIDTH'(1);
        rf_wr_data_next = rx_p_data;
        state_next      = (state_reg == OP_A) ? OP_B : ALU_FUN;
      end
      ALU_FUN: if (rx_d_vld) begin
        alu_fun_next  = rx_p_data[3:0];
        alu_en_next   = 1'b1;
        clk_gate_next = 1'b1;
        state_next    = ALU_WAIT;
      end
      // Gate stays open through the alu_out_vld cycle and closes one cycle later.
      ALU_WAIT: if (alu_out_vld) begin
        result_next   = alu_out;
        clk_gate_next = 1'b0;
        state_next    = TX_LSB;
      end
      TX_RD, TX_LSB, TX_MSB: begin
        if (!tx_vld_reg) begin
          if (!tx_busy) begin
            tx_vld_next  = 1'b1;
            tx_data_next = tx_byte;
          end
        end else if (tx_busy) begin
          tx_vld_next = 1'b0;
          state_next  = tx_after;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clck) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      rd_data_reg    <= '0;
      result_reg     <= '0;
      rf_addr_reg    <= '0;
      rf_wr_en_reg   <= 1'b0;
      rf_rd_en_reg   <= 1'b0;
      rf_wr_data_reg <= '0;
      alu_fun_reg    <= '0;
      alu_en_reg     <= 1'b0;
      clk_gate_reg   <= 1'b0;
      tx_data_reg    <= '0;
      tx_vld_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      rd_data_reg    <= rd_data_next;
      result_reg     <= result_next;
      rf_addr_reg    <= rf_addr_next;
      rf_wr_en_reg   <= rf_wr_en_next;
      rf_rd_en_reg   <= rf_rd_en_next;
      rf_wr_data_reg <= rf_wr_data_next;
      alu_fun_reg    <= alu_fun_next;
      alu_en_reg     <= alu_en_next;
      clk_gate_reg   <= clk_gate_next;
      tx_data_reg    <= tx_data_next;
      tx_vld_reg     <= tx_vld_next;
    end
  end

  assign rf_addr     = rf_addr_reg;
  assign rf_wr_en    = rf_wr_en_reg;
  assign rf_rd_en    = rf_rd_en_reg;
  assign rf_wr_data  = rf_wr_data_reg;
  assign alu_fun     = alu_fun_reg;
  assign alu_en      = alu_en_reg;
  assign clk_gate_en = clk_gate_reg;
  assign tx_p_data   = tx_data_reg;
  assign tx_d_vld    = tx_vld_reg;

endmodule
